// File: rtl/gpp_stack_unit.sv
// gpp_stack_unit: dedicated LIFO stack for the gpp_calc core.
// Push/pop/replace-top per cycle, occupancy status, sticky overflow and
// underflow flags, and a multi-cycle scrub that zeroes every entry.
module gpp_stack_unit #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    input  logic                     scrub,
    input  logic                     err_clr,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(DEPTH - 1);

    typedef enum logic {
        READY = 1'b0,
        SCRUB = 1'b1
    } state_t;

    // Storage is deliberately left unreset so it maps onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [PTR_W-1:0]  idx_reg, idx_next;
    logic [DATA_W-1:0] dout_reg;
    logic              dout_valid_reg;
    logic              overflow_reg;
    logic              underflow_reg;

    // Per-cycle decode results
    logic              wr_en;
    logic [PTR_W-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic              ovf_set;
    logic              unf_set;

    // Derived pointers: write pointer is count, top of stack is count-1.
    logic [CNT_W-1:0]  count_inc;
    logic [CNT_W-1:0]  count_dec;
    logic [PTR_W-1:0]  push_addr;
    logic [PTR_W-1:0]  top_addr;

    assign count_inc = count_reg + CNT_W'(1);
    assign count_dec = count_reg - CNT_W'(1);
    assign push_addr = count_reg[PTR_W-1:0];
    assign top_addr  = count_dec[PTR_W-1:0];

    // Status flags straight from the occupancy register.
    assign empty       = (count_reg == '0);
    assign full        = (count_reg == DEPTH_CNT);
    assign almost_full = (count_reg >= AF_CNT);
    assign busy        = (state_reg == SCRUB);

    assign count      = count_reg;
    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign overflow   = overflow_reg;
    assign underflow  = underflow_reg;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= READY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and operation decode; scrub wins over push/pop in READY.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        idx_next   = idx_reg;
        wr_en      = 1'b0;
        wr_addr    = push_addr;
        wr_data    = din;
        rd_en      = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        case (state_reg)
            READY: begin
                if (scrub) begin
                    state_next = SCRUB;
                    count_next = '0;
                    idx_next   = '0;
                end else begin
                    case ({push, pop})
                        2'b10: begin
                            if (!full) begin
                                wr_en      = 1'b1;
                                count_next = count_inc;
                            end else begin
                                ovf_set = 1'b1;
                            end
                        end
                        2'b01: begin
                            if (!empty) begin
                                rd_en      = 1'b1;
                                count_next = count_dec;
                            end else begin
                                unf_set = 1'b1;
                            end
                        end
                        2'b11: begin
                            if (!empty) begin
                                // Replace-top: old top goes out, din takes its slot.
                                rd_en   = 1'b1;
                                wr_en   = 1'b1;
                                wr_addr = top_addr;
                            end else begin
                                // Nothing to pop: degrade to a plain push.
                                wr_en      = 1'b1;
                                count_next = count_inc;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            SCRUB: begin
                wr_en    = 1'b1;
                wr_addr  = idx_reg;
                wr_data  = '0;
                idx_next = idx_reg + PTR_W'(1);
                if (idx_reg == LAST_IDX) begin
                    state_next = READY;
                end
            end
            default: state_next = READY;
        endcase
    end

    // Occupancy, scrub index, pop data and error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg      <= '0;
            idx_reg        <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            count_reg      <= count_next;
            idx_reg        <= idx_next;
            dout_valid_reg <= rd_en;
            if (rd_en) begin
                dout_reg <= mem[top_addr];
            end
            // A new error in the same cycle as err_clr keeps the flag set.
            if (ovf_set) begin
                overflow_reg <= 1'b1;
            end else if (err_clr) begin
                overflow_reg <= 1'b0;
            end
            if (unf_set) begin
                underflow_reg <= 1'b1;
            end else if (err_clr) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    // Storage write port; suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (wr_en && rst) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_gpp_stack_unit.sv
// Directed self-checking bench for gpp_stack_unit (DATA_W=16, DEPTH=16, AF_THRESH=14).
module tb_gpp_stack_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [15:0] din = 16'h0;
    logic        scrub = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] dout;
    logic        dout_valid;
    logic [4:0]  count;
    logic        empty, full, almost_full, overflow, underflow, busy;

    int checks = 0;
    int failures = 0;

    gpp_stack_unit #(.DATA_W(16), .DEPTH(16), .AF_THRESH(14)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
        .scrub(scrub), .err_clr(err_clr), .dout(dout), .dout_valid(dout_valid),
        .count(count), .empty(empty), .full(full), .almost_full(almost_full),
        .overflow(overflow), .underflow(underflow), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic p, input logic q, input logic [15:0] d);
        push = p; pop = q; din = d;
        step();
        push = 1'b0; pop = 1'b0;
        $display("txn push=%0b pop=%0b din=%h -> dout=%h dv=%0b count=%0d", p, q, d, dout, dout_valid, count);
    endtask

    task automatic apply_reset();
        push = 0; pop = 0; scrub = 0; err_clr = 0; din = 0;
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_af: got %b expected 0", almost_full); end
        checks++; if (dout !== 16'h0) begin failures++; $display("FAIL reset_dout: got %h expected 0000", dout); end
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_dv: got %b expected 0", dout_valid); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL reset_err: got ovf=%b unf=%b expected 0 0", overflow, underflow); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        step();
        rst = 1'b1;
    endtask

    task automatic test_lifo();
        apply_reset();
        cyc(1, 0, 16'h1111); cyc(1, 0, 16'h2222); cyc(1, 0, 16'h3333);
        checks++; if (count !== 5'd3) begin failures++; $display("FAIL lifo_count3: got %0d expected 3", count); end
        cyc(0, 1, 16'h0);
        checks++; if (dout !== 16'h3333 || dout_valid !== 1'b1) begin failures++; $display("FAIL lifo_pop1: got %h dv=%b expected 3333 dv=1", dout, dout_valid); end
        cyc(0, 1, 16'h0);
        checks++; if (dout !== 16'h2222 || dout_valid !== 1'b1) begin failures++; $display("FAIL lifo_pop2: got %h dv=%b expected 2222 dv=1", dout, dout_valid); end
        cyc(0, 1, 16'h0);
        checks++; if (dout !== 16'h1111 || dout_valid !== 1'b1) begin failures++; $display("FAIL lifo_pop3: got %h dv=%b expected 1111 dv=1", dout, dout_valid); end
        cyc(0, 0, 16'h0);
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL lifo_dv_pulse: got %b expected 0", dout_valid); end
        checks++; if (dout !== 16'h1111) begin failures++; $display("FAIL lifo_dout_hold: got %h expected 1111", dout); end
        checks++; if (empty !== 1'b1 || count !== 5'd0) begin failures++; $display("FAIL lifo_end: got empty=%b count=%0d expected 1 0", empty, count); end
    endtask

    task automatic test_full_overflow();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 16'h0100 + 16'(i));
            checks++; if (count !== 5'(i + 1)) begin failures++; $display("FAIL fill_count_%0d: got %0d expected %0d", i, count, i + 1); end
            checks++; if (almost_full !== ((i + 1) >= 14)) begin failures++; $display("FAIL fill_af_%0d: got %b expected %b", i, almost_full, ((i + 1) >= 14)); end
            checks++; if (full !== ((i + 1) == 16)) begin failures++; $display("FAIL fill_full_%0d: got %b expected %b", i, full, ((i + 1) == 16)); end
        end
        cyc(1, 0, 16'hDEAD);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        checks++; if (count !== 5'd16) begin failures++; $display("FAIL ovf_count: got %0d expected 16", count); end
        cyc(0, 1, 16'h0);
        checks++; if (dout !== 16'h010F || dout_valid !== 1'b1) begin failures++; $display("FAIL ovf_pop: got %h dv=%b expected 010f dv=1", dout, dout_valid); end
        checks++; if (count !== 5'd15 || full !== 1'b0) begin failures++; $display("FAIL ovf_pop_count: got %0d full=%b expected 15 0", count, full); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        err_clr = 1'b1; step(); err_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_underflow();
        apply_reset();
        cyc(1, 0, 16'h0BAD);
        cyc(0, 1, 16'h0);
        checks++; if (dout !== 16'h0BAD) begin failures++; $display("FAIL unf_prepop: got %h expected 0bad", dout); end
        cyc(0, 1, 16'h0);
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL unf_set: got %b expected 1", underflow); end
        checks++; if (dout_valid !== 1'b0 || dout !== 16'h0BAD) begin failures++; $display("FAIL unf_dout: got %h dv=%b expected 0bad dv=0", dout, dout_valid); end
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL unf_count: got %0d expected 0", count); end
        err_clr = 1'b1; step(); err_clr = 1'b0;
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL unf_clear: got %b expected 0", underflow); end
        err_clr = 1'b1; pop = 1'b1; step(); err_clr = 1'b0; pop = 1'b0;
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL unf_set_wins: got %b expected 1", underflow); end
        err_clr = 1'b1; step(); err_clr = 1'b0;
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL unf_clear2: got %b expected 0", underflow); end
    endtask

    task automatic test_replace();
        apply_reset();
        cyc(1, 0, 16'h0001); cyc(1, 0, 16'h0002); cyc(1, 0, 16'hAAAA);
        cyc(1, 1, 16'h5555);
        checks++; if (dout !== 16'hAAAA || dout_valid !== 1'b1) begin failures++; $display("FAIL rep_dout: got %h dv=%b expected aaaa dv=1", dout, dout_valid); end
        checks++; if (count !== 5'd3) begin failures++; $display("FAIL rep_count: got %0d expected 3", count); end
        cyc(0, 1, 16'h0);
        checks++; if (dout !== 16'h5555 || count !== 5'd2) begin failures++; $display("FAIL rep_newtop: got %h count=%0d expected 5555 2", dout, count); end
        cyc(0, 1, 16'h0);
        checks++; if (dout !== 16'h0002 || count !== 5'd1) begin failures++; $display("FAIL rep_below: got %h count=%0d expected 0002 1", dout, count); end
        // replace-top on a full stack
        apply_reset();
        for (int i = 0; i < 16; i++) cyc(1, 0, 16'h0200 + 16'(i));
        cyc(1, 1, 16'h7777);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rep_full_ovf: got %b expected 0", overflow); end
        checks++; if (count !== 5'd16 || dout !== 16'h020F) begin failures++; $display("FAIL rep_full: got count=%0d dout=%h expected 16 020f", count, dout); end
        cyc(0, 1, 16'h0);
        checks++; if (dout !== 16'h7777) begin failures++; $display("FAIL rep_full_pop: got %h expected 7777", dout); end
        // push+pop on empty acts as push
        apply_reset();
        cyc(1, 1, 16'h6666);
        checks++; if (count !== 5'd1 || underflow !== 1'b0 || dout_valid !== 1'b0) begin failures++; $display("FAIL rep_empty: got count=%0d unf=%b dv=%b expected 1 0 0", count, underflow, dout_valid); end
        cyc(0, 1, 16'h0);
        checks++; if (dout !== 16'h6666) begin failures++; $display("FAIL rep_empty_pop: got %h expected 6666", dout); end
    endtask

    task automatic test_scrub();
        int busy_cycles;
        int k;
        apply_reset();
        for (int i = 0; i < 5; i++) cyc(1, 0, 16'h0300 + 16'(i));
        scrub = 1'b1; step(); scrub = 1'b0;
        $display("txn scrub start -> busy=%0b count=%0d", busy, count);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL scrub_busy: got %b expected 1", busy); end
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin failures++; $display("FAIL scrub_count: got %0d empty=%b expected 0 1", count, empty); end
        busy_cycles = 0;
        k = 0;
        while (busy === 1'b1 && k < 40) begin
            busy_cycles++;
            push  = (k % 2 == 0);
            pop   = (k % 2 == 1);
            din   = 16'hF000 + 16'(k);
            scrub = (k == 3);
            step();
            k++;
        end
        push = 0; pop = 0; scrub = 0;
        $display("txn scrub end -> busy_cycles=%0d count=%0d", busy_cycles, count);
        checks++; if (busy_cycles !== 16) begin failures++; $display("FAIL scrub_len: got %0d expected 16", busy_cycles); end
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL scrub_ignore_ops: got count=%0d expected 0", count); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL scrub_no_err: got ovf=%b unf=%b expected 0 0", overflow, underflow); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (dut.mem[i] !== 16'h0) begin failures++; $display("FAIL scrub_mem_%0d: got %h expected 0000", i, dut.mem[i]); end
        end
        cyc(1, 0, 16'h1234);
        cyc(0, 1, 16'h0);
        checks++; if (dout !== 16'h1234 || count !== 5'd0) begin failures++; $display("FAIL scrub_after: got %h count=%0d expected 1234 0", dout, count); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        cyc(1, 0, 16'hBEEF);
        cyc(0, 1, 16'h0);
        cyc(0, 1, 16'h0);
        cyc(1, 0, 16'h0001);
        cyc(1, 0, 16'h0002);
        scrub = 1'b1; step(); scrub = 1'b0;
        repeat (7) step();
        checks++; if (busy !== 1'b1 || underflow !== 1'b1 || dout !== 16'hBEEF) begin failures++; $display("FAIL ar_pre: got busy=%b unf=%b dout=%h expected 1 1 beef", busy, underflow, dout); end
        #2; rst = 1'b0; #1;
        $display("txn async reset mid-scrub -> busy=%0b count=%0d dout=%h", busy, count, dout);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ar_scrub_busy: got %b expected 0", busy); end
        checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin failures++; $display("FAIL ar_scrub_status: got count=%0d e=%b f=%b af=%b expected 0 1 0 0", count, empty, full, almost_full); end
        checks++; if (dout !== 16'h0 || underflow !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL ar_scrub_regs: got dout=%h unf=%b ovf=%b expected 0000 0 0", dout, underflow, overflow); end
        #2; rst = 1'b1;
        step();
        cyc(1, 0, 16'hA1A1);
        cyc(1, 0, 16'hB2B2);
        pop = 1'b1; step(); pop = 1'b0;
        checks++; if (dout_valid !== 1'b1 || dout !== 16'hB2B2) begin failures++; $display("FAIL ar_prepush: got dv=%b dout=%h expected 1 b2b2", dout_valid, dout); end
        push = 1'b1; din = 16'hC3C3;
        #2; rst = 1'b0; #1;
        $display("txn async reset mid-push -> dv=%0b count=%0d dout=%h", dout_valid, count, dout);
        checks++; if (dout_valid !== 1'b0 || dout !== 16'h0) begin failures++; $display("FAIL ar_push_dout: got dv=%b dout=%h expected 0 0000", dout_valid, dout); end
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin failures++; $display("FAIL ar_push_count: got %0d empty=%b expected 0 1", count, empty); end
        push = 1'b0;
        #2; rst = 1'b1;
        step();
        cyc(1, 0, 16'h4242);
        checks++; if (count !== 5'd1) begin failures++; $display("FAIL ar_after_push: got %0d expected 1", count); end
        cyc(0, 1, 16'h0);
        checks++; if (dout !== 16'h4242 || dout_valid !== 1'b1) begin failures++; $display("FAIL ar_after_pop: got %h dv=%b expected 4242 1", dout, dout_valid); end
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_full_overflow();
        test_underflow();
        test_replace();
        test_scrub();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
